// File: rtl/rdata_disassembler.sv
// rdata_disassembler
//   Read-path half of the load/store unit. Takes one warp load at a time,
//   collects the memory read-response blocks that serve its threads, pulls
//   each thread's bytes out of a block at that thread's byte offset, zero- or
//   sign-extends them to RegWidth and presents the finished warp result to
//   register writeback with a valid/ready handshake.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_valid_i/ready_o  new warp load handshake
//   req_act_mask_i       threads that expect data
//   req_width_i          access size code w, 2^w bytes (saturates at RegWidth)
//   req_signed_i         1 = sign-extend, 0 = zero-extend
//   req_tag_i            opaque tag carried to writeback
//   rsp_valid_i/ready_o  memory response block handshake
//   rsp_data_i           block data, byte i at bits [8i+7:8i]
//   rsp_thread_mask_i    threads served by this block
//   rsp_block_offsets_i  per-thread byte offset, thread t at [t*BlockIdxBits +: BlockIdxBits]
//   wb_valid_o/ready_i   warp result handshake
//   wb_tag_o, wb_act_mask_o, wb_data_o  registered warp result (lane t at [t*RegWidth +: RegWidth])

module rdata_disassembler #(
    parameter int RegWidth     = 32,
    parameter int WarpWidth    = 4,
    parameter int BlockIdxBits = 4,
    parameter int TagWidth     = 4,
    localparam int BlockWidth      = 2 ** BlockIdxBits,
    localparam int RegWidthInBytes = (RegWidth + 7) / 8,
    localparam int WriteWidthBits  = (RegWidthInBytes > 1) ? $clog2(RegWidthInBytes) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [WarpWidth-1:0]              req_act_mask_i,
    input  logic [WriteWidthBits-1:0]         req_width_i,
    input  logic                              req_signed_i,
    input  logic [TagWidth-1:0]               req_tag_i,
    input  logic                              rsp_valid_i,
    output logic                              rsp_ready_o,
    input  logic [8*BlockWidth-1:0]           rsp_data_i,
    input  logic [WarpWidth-1:0]              rsp_thread_mask_i,
    input  logic [WarpWidth*BlockIdxBits-1:0] rsp_block_offsets_i,
    output logic                              wb_valid_o,
    input  logic                              wb_ready_i,
    output logic [TagWidth-1:0]               wb_tag_o,
    output logic [WarpWidth-1:0]              wb_act_mask_o,
    output logic [RegWidth*WarpWidth-1:0]     wb_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITEBACK
    } state_t;

    state_t                             state_q, state_d;
    logic [WarpWidth-1:0]               pending_q;
    logic [WarpWidth-1:0]               act_q;
    logic [WriteWidthBits-1:0]          width_q;
    logic                               signed_q;
    logic [TagWidth-1:0]                tag_q;
    logic [WarpWidth-1:0][RegWidth-1:0] data_q;
    logic [WarpWidth-1:0][RegWidth-1:0] lane_val;

    logic req_fire;
    logic rsp_fire;

    // Pull 2^w bytes starting at byte 'off' out of the block. Bytes that fall
    // past the end of the block read as zero; bytes above the access size are
    // filled with the sign bit of the top accessed byte when signed. Width codes
    // that exceed the register saturate to a full-register copy, which leaves
    // no fill bytes and therefore no extension.
    function automatic logic [RegWidth-1:0] extract(
        input logic [8*BlockWidth-1:0]    data,
        input logic [BlockIdxBits-1:0]    off,
        input logic [WriteWidthBits-1:0]  w,
        input logic                       sgn
    );
        logic [8*RegWidthInBytes-1:0] res;
        logic [7:0]                   b;
        logic                         fill;
        int                           nbytes;
        int                           idx;
        res    = '0;
        fill   = 1'b0;
        nbytes = 1 << w;
        if (nbytes > RegWidthInBytes) nbytes = RegWidthInBytes;
        for (int j = 0; j < RegWidthInBytes; j++) begin
            if (j < nbytes) begin
                idx = int'(off) + j;
                b   = (idx < BlockWidth) ? data[idx*8 +: 8] : 8'h00;
                res[j*8 +: 8] = b;
                if (j == nbytes - 1) fill = sgn & b[7];
            end else begin
                res[j*8 +: 8] = {8{fill}};
            end
        end
        return res[RegWidth-1:0];
    endfunction

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        lane_val = '0;
        for (int t = 0; t < WarpWidth; t++) begin
            lane_val[t] = extract(rsp_data_i,
                                  rsp_block_offsets_i[t*BlockIdxBits +: BlockIdxBits],
                                  width_q, signed_q);
        end
    end

    assign req_fire = req_valid_i & (state_q == ST_IDLE);
    assign rsp_fire = rsp_valid_i & (state_q == ST_COLLECT);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs, all decoded from the registered state
    // so nothing on the request or response side reaches wb_* combinationally.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_ready_o = 1'b0;
        wb_valid_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = (req_act_mask_i == '0) ? ST_WRITEBACK : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                rsp_ready_o = 1'b1;
                // Leave once this block covers every thread still waiting.
                if (rsp_valid_i && ((pending_q & ~rsp_thread_mask_i) == '0)) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Load context and result buffer.
    // NOTE: the result buffer is reset as well as cleared on each new load;
    // it drives wb_data_o directly, which must read zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            act_q     <= '0;
            width_q   <= '0;
            signed_q  <= 1'b0;
            tag_q     <= '0;
            data_q    <= '0;
        end else if (req_fire) begin
            pending_q <= req_act_mask_i;
            act_q     <= req_act_mask_i;
            width_q   <= req_width_i;
            signed_q  <= req_signed_i;
            tag_q     <= req_tag_i;
            data_q    <= '0;
        end else if (rsp_fire) begin
            // Only threads still pending take data; repeats are ignored so an
            // already-filled lane is never overwritten.
            for (int t = 0; t < WarpWidth; t++) begin
                if (rsp_thread_mask_i[t] && pending_q[t]) begin
                    data_q[t]    <= lane_val[t];
                    pending_q[t] <= 1'b0;
                end
            end
        end
    end

    assign wb_tag_o      = tag_q;
    assign wb_act_mask_o = act_q;
    assign wb_data_o     = data_q;

endmodule
